// File: rtl/axil_ram_slave.sv
// AXI-lite slave backed by an inferred single-clock RAM.
// Independent read/write channels, byte-strobe writes, DECERR on
// out-of-range word indices, optional registered read output stage.
module axil_ram_slave #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int MEM_DEPTH       = 1024,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,

  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [IDX_W-1:0]  aw_idx;
  logic [IDX_W-1:0]  ar_idx;
  logic [MEM_AW-1:0] aw_word;
  logic [MEM_AW-1:0] ar_word;
  logic              aw_ok;
  logic              ar_ok;

  assign aw_idx  = s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign ar_idx  = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign aw_word = aw_idx[MEM_AW-1:0];
  assign ar_word = ar_idx[MEM_AW-1:0];
  assign aw_ok   = (64'(aw_idx) < 64'(MEM_DEPTH));
  assign ar_ok   = (64'(ar_idx) < 64'(MEM_DEPTH));

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_rdata_q;

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  logic       aw_hs;
  logic       bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;

  // AW and W are only ever taken together, and only when the B slot frees.
  always_comb begin
    aw_hs    = s_axil_awvalid & s_axil_wvalid & (!bvalid_q | s_axil_bready) & !rst;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (aw_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_ok ? RESP_OKAY : RESP_DECERR;
    end else if (s_axil_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Write response registers; dropped immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  // Byte-strobed RAM write; out-of-range writes never touch the array.
  always_ff @(posedge clk) begin
    if (aw_hs && aw_ok) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axil_wstrb[i]) begin
          mem[aw_word][i*8 +: 8] <= s_axil_wdata[i*8 +: 8];
        end
      end
    end
  end

  assign s_axil_awready = aw_hs;
  assign s_axil_wready  = aw_hs;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;

  // ---------------------------------------------------------------------
  // Read stage 1: RAM read register plus its valid/response flags
  // ---------------------------------------------------------------------
  logic                  ar_hs;
  logic                  s1_adv;
  logic                  s1_valid_q, s1_valid_d;
  logic [1:0]            s1_resp_q, s1_resp_d;
  logic [DATA_WIDTH-1:0] s1_data;

  // Stage 1 accepts a new address when empty or when its content moves on.
  always_comb begin
    ar_hs      = s_axil_arvalid & (!s1_valid_q | s1_adv) & !rst;
    s1_valid_d = s1_valid_q;
    s1_resp_d  = s1_resp_q;
    if (ar_hs) begin
      s1_valid_d = 1'b1;
      s1_resp_d  = ar_ok ? RESP_OKAY : RESP_DECERR;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 1 control flags with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_resp_q  <= 2'b00;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_resp_q  <= s1_resp_d;
    end
  end

  // Registered RAM read; nonblocking write above makes a same-cycle
  // read of the same word return the old contents.
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      ram_rdata_q <= mem[ar_word];
    end
  end

  // Out-of-range or empty slots present zero data instead of stale RAM output.
  assign s1_data = (s1_valid_q && (s1_resp_q == RESP_OKAY)) ? ram_rdata_q : '0;

  assign s_axil_arready = ar_hs | (!rst & (!s1_valid_q | s1_adv) & !s_axil_arvalid);

  // ---------------------------------------------------------------------
  // Read output: direct from stage 1, or through a second register
  // ---------------------------------------------------------------------
  generate
    if (PIPELINE_OUTPUT != 0) begin : g_pipe
      logic                  s2_load;
      logic                  s2_valid_q, s2_valid_d;
      logic [1:0]            s2_resp_q, s2_resp_d;
      logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

      // Stage 2 takes stage 1 whenever it is empty or being drained.
      always_comb begin
        s2_load    = !s2_valid_q | s_axil_rready;
        s2_valid_d = s2_valid_q;
        s2_resp_d  = s2_resp_q;
        s2_data_d  = s2_data_q;
        if (s2_load) begin
          s2_valid_d = s1_valid_q;
          s2_resp_d  = s1_valid_q ? s1_resp_q : 2'b00;
          s2_data_d  = s1_data;
        end
      end

      // Output register stage with asynchronous clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_resp_q  <= 2'b00;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_resp_q  <= s2_resp_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign s1_adv        = s2_load;
      assign s_axil_rvalid = s2_valid_q;
      assign s_axil_rresp  = s2_resp_q;
      assign s_axil_rdata  = s2_data_q;
    end else begin : g_direct
      assign s1_adv        = s_axil_rready;
      assign s_axil_rvalid = s1_valid_q;
      assign s_axil_rresp  = s1_resp_q;
      assign s_axil_rdata  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_axil_ram_slave.sv
// Directed bench for axil_ram_slave: one instance per PIPELINE_OUTPUT
// setting, each driven through the same transaction sequence.
module tb_axil_ram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic [15:0] awaddr  [2];
  logic [2:0]  awprot  [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic [1:0]  bresp   [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic [15:0] araddr  [2];
  logic [2:0]  arprot  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        rvalid  [2];
  logic        rready  [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      axil_ram_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(1024), .PIPELINE_OUTPUT(gi)
      ) u_dut (
        .clk(clk), .rst(rst[gi]),
        .s_axil_awaddr(awaddr[gi]), .s_axil_awprot(awprot[gi]),
        .s_axil_awvalid(awvalid[gi]), .s_axil_awready(awready[gi]),
        .s_axil_wdata(wdata[gi]), .s_axil_wstrb(wstrb[gi]),
        .s_axil_wvalid(wvalid[gi]), .s_axil_wready(wready[gi]),
        .s_axil_bresp(bresp[gi]), .s_axil_bvalid(bvalid[gi]), .s_axil_bready(bready[gi]),
        .s_axil_araddr(araddr[gi]), .s_axil_arprot(arprot[gi]),
        .s_axil_arvalid(arvalid[gi]), .s_axil_arready(arready[gi]),
        .s_axil_rdata(rdata[gi]), .s_axil_rresp(rresp[gi]),
        .s_axil_rvalid(rvalid[gi]), .s_axil_rready(rready[gi])
      );
    end
  endgenerate

  int n_vec = 0;
  int n_err = 0;
  int cur_d = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL pipe%0d %s: got 0x%0h, expected 0x%0h", cur_d, tag, got, exp);
    end
  endtask

  function automatic logic [31:0] burst_val(input int i);
    return 32'hB000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic do_write(input int d, input logic [15:0] a, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr[d] = a; wdata[d] = data; wstrb[d] = strb;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1; bready[d] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready[d] && n < 50);
    chk("aw_accept", {awready[d], wready[d]}, 2'b11);
    @(posedge clk); #1;
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid[d] && n < 50) begin @(negedge clk); n++; end
    chk("bvalid", bvalid[d], 1'b1);
    resp = bresp[d];
    @(posedge clk); #1;
    $display("[pipe%0d] WR addr=0x%04h data=0x%08h strb=%b bresp=%0d", d, a, data, strb, resp);
  endtask

  task automatic wait_r(input int d, output logic [31:0] data, output logic [1:0] resp,
                        output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid[d] && lat < 50);
    chk("rvalid", rvalid[d], 1'b1);
    data = rdata[d]; resp = rresp[d];
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int d, input logic [15:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready[d] && n < 50);
    chk("ar_accept", arready[d], 1'b1);
    @(posedge clk); #1;
    arvalid[d] = 1'b0;
    wait_r(d, data, resp, lat);
    $display("[pipe%0d] RD addr=0x%04h data=0x%08h rresp=%0d lat=%0d", d, a, data, resp, lat);
  endtask

  task automatic burst(input int d);
    int got_n, issued, extra;
    got_n = 0; issued = 0; extra = 0;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] r;
      do_write(d, 16'(i * 4), burst_val(i), 4'hF, r);
    end
    araddr[d] = 16'h0000; arvalid[d] = 1'b1;
    rready[d] = 1'($urandom_range(0, 1));
    fork
      begin
        for (int c = 0; c < 300 && issued < 8; c++) begin
          logic hs;
          @(negedge clk); hs = arready[d];
          @(posedge clk); #1;
          if (hs) begin
            issued++;
            if (issued == 8) arvalid[d] = 1'b0;
            else araddr[d] = 16'(issued * 4);
          end
        end
        arvalid[d] = 1'b0;
      end
      begin
        for (int c = 0; c < 300 && got_n < 8; c++) begin
          @(negedge clk);
          if (rvalid[d] && rready[d]) begin
            chk("burst_data", rdata[d], burst_val(got_n));
            $display("[pipe%0d] RD burst #%0d data=0x%08h rresp=%0d", d, got_n, rdata[d], rresp[d]);
            got_n++;
          end
          @(posedge clk); #1;
          rready[d] = 1'($urandom_range(0, 1));
        end
      end
    join
    chk("burst_count", 64'(got_n), 64'd8);
    rready[d] = 1'b1;
    repeat (10) begin @(negedge clk); if (rvalid[d]) extra++; end
    chk("burst_extra", 64'(extra), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_seq(input int d);
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat, n;
    cur_d = d;

    // Basic write / read-back with latency
    do_write(d, 16'h0010, 32'hDEAD_BEEF, 4'hF, resp);
    chk("wr_bresp", resp, 2'b00);
    do_read(d, 16'h0010, data, resp, lat);
    chk("rd_data", data, 32'hDEAD_BEEF);
    chk("rd_rresp", resp, 2'b00);
    chk("rd_latency", 64'(lat), 64'(d + 1));

    // Byte strobes
    do_write(d, 16'h0020, 32'h1122_3344, 4'hF, resp);
    do_write(d, 16'h0020, 32'hAABB_CCDD, 4'b0101, resp);
    do_read(d, 16'h0020, data, resp, lat);
    chk("strb_data", data, 32'h11BB_33DD);

    // Same-cycle read and write of one word
    do_write(d, 16'h0008, 32'h0000_0001, 4'hF, resp);
    awaddr[d] = 16'h0008; wdata[d] = 32'h0000_0002; wstrb[d] = 4'hF;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1; araddr[d] = 16'h0008; arvalid[d] = 1'b1;
    @(negedge clk);
    chk("coll_ready", {awready[d], arready[d]}, 2'b11);
    @(posedge clk); #1;
    awvalid[d] = 1'b0; wvalid[d] = 1'b0; arvalid[d] = 1'b0;
    fork
      begin @(negedge clk); chk("coll_bvalid", bvalid[d], 1'b1); end
      wait_r(d, data, resp, lat);
    join
    $display("[pipe%0d] RD/WR collision addr=0x0008 data=0x%08h", d, data);
    chk("coll_old", data, 32'h0000_0001);
    do_read(d, 16'h0008, data, resp, lat);
    chk("coll_new", data, 32'h0000_0002);

    // Out-of-range access
    do_write(d, 16'h0000, 32'h0123_4567, 4'hF, resp);
    do_write(d, 16'h1000, 32'hCAFE_F00D, 4'hF, resp);
    chk("oor_bresp", resp, 2'b11);
    do_read(d, 16'h1000, data, resp, lat);
    chk("oor_rresp", resp, 2'b11);
    chk("oor_rdata", data, 32'h0);
    do_read(d, 16'h0000, data, resp, lat);
    chk("oor_idx0", data, 32'h0123_4567);

    // Burst with random rready
    burst(d);

    // Reset with both responses pending
    do_write(d, 16'h0040, 32'h5A5A_1234, 4'hF, resp);
    bready[d] = 1'b0; rready[d] = 1'b0;
    awaddr[d] = 16'h0044; wdata[d] = 32'h0000_0077; wstrb[d] = 4'hF;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1; araddr[d] = 16'h0040; arvalid[d] = 1'b1;
    @(negedge clk);
    chk("rst_pre_ready", {awready[d], arready[d]}, 2'b11);
    @(posedge clk); #1;
    awvalid[d] = 1'b0; wvalid[d] = 1'b0; arvalid[d] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bvalid[d] && rvalid[d]) && n < 10);
    chk("rst_pending", {bvalid[d], rvalid[d]}, 2'b11);
    rst[d] = 1'b1;
    awaddr[d] = 16'h0040; wdata[d] = 32'hFFFF_FFFF; awvalid[d] = 1'b1; wvalid[d] = 1'b1;
    #1;
    chk("rst_valids", {bvalid[d], rvalid[d]}, 2'b00);
    chk("rst_readys", {awready[d], wready[d], arready[d]}, 3'b000);
    chk("rst_rdata", rdata[d], 32'h0);
    $display("[pipe%0d] RESET asserted with pending B and R", d);
    @(posedge clk); @(posedge clk); @(negedge clk);
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    rst[d] = 1'b0; bready[d] = 1'b1; rready[d] = 1'b1;
    @(posedge clk); #1;
    do_read(d, 16'h0040, data, resp, lat);
    chk("rst_keep", data, 32'h5A5A_1234);
    do_read(d, 16'h0044, data, resp, lat);
    chk("rst_commit", data, 32'h0000_0077);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; awaddr[i] = '0; awprot[i] = '0; awvalid[i] = 1'b0;
      wdata[i] = '0; wstrb[i] = '0; wvalid[i] = 1'b0; bready[i] = 1'b1;
      araddr[i] = '0; arprot[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b1;
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cur_d = i;
      chk("reset_valids", {bvalid[i], rvalid[i]}, 2'b00);
      chk("reset_readys", {awready[i], wready[i], arready[i]}, 3'b000);
      chk("reset_out", {bresp[i], rresp[i], rdata[i]}, 36'h0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;
    run_seq(0);
    run_seq(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
